// File: rtl/dro_pulse_driver.sv
// Serialises a word into DRO data/readout pulse pairs and reassembles the DRO echoes.
// Optional loopback compare is enabled with `define DRO_LOOPBACK_CHK_EN.
module dro_pulse_driver #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 3,
  parameter int HOLD_CYC  = 2,
  parameter int OUT_WIN   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             d_pulse,
  output logic             clk_pulse,
  input  logic             dro_out,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             err_extra,
  output logic             mismatch
);

  localparam int WAIT_CYC = (OUT_WIN > HOLD_CYC) ? OUT_WIN : HOLD_CYC;
  localparam int MAX_A    = (SETUP_CYC > WAIT_CYC) ? SETUP_CYC : WAIT_CYC;
  localparam int CNT_MAX  = (MAX_A > WIDTH) ? MAX_A : WIDTH;
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] WIN_LEN    = CW'(OUT_WIN);
  localparam logic [CW-1:0] BIT_LAST   = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_SETUP, S_CLOCK, S_WAIT, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CW-1:0]    bit_idx, bit_nxt;
  logic [WIDTH-1:0] tx_shift, tx_shift_nxt;
  logic [WIDTH-1:0] rx_shift, rx_shift_nxt;
  logic             hit, hit_nxt;
  logic             in_win, sample, stray, accept;

  assign tx_ready = (state == S_IDLE);
  assign accept   = tx_ready && tx_valid;
  assign in_win   = (state == S_WAIT) && (cnt < WIN_LEN);
  assign sample   = hit || (in_win && dro_out);
  // Any DRO output outside a sample window (including DONE and late WAIT) is stray.
  assign stray    = dro_out && !in_win;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_nxt      = bit_idx;
    tx_shift_nxt = tx_shift;
    rx_shift_nxt = rx_shift;
    hit_nxt      = hit;
    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          state_nxt    = S_DATA;
          tx_shift_nxt = tx_data;
          rx_shift_nxt = '0;
          bit_nxt      = '0;
        end
      end
      S_DATA: begin
        state_nxt = S_SETUP;
        cnt_nxt   = '0;
        hit_nxt   = 1'b0;
      end
      S_SETUP: begin
        if (cnt == SETUP_LAST) state_nxt = S_CLOCK;
        else                   cnt_nxt   = cnt + CW'(1);
      end
      S_CLOCK: begin
        state_nxt = S_WAIT;
        cnt_nxt   = '0;
      end
      S_WAIT: begin
        hit_nxt = sample;
        if (cnt == WAIT_LAST) begin
          // Received bits enter at the MSB so that bit 0 ends up at the LSB.
          rx_shift_nxt            = rx_shift >> 1;
          rx_shift_nxt[WIDTH-1]   = sample;
          if (bit_idx == BIT_LAST) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt    = S_DATA;
            bit_nxt      = bit_idx + CW'(1);
            tx_shift_nxt = tx_shift >> 1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      hit      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_nxt;
      tx_shift <= tx_shift_nxt;
      rx_shift <= rx_shift_nxt;
      hit      <= hit_nxt;
    end
  end

  // Pulse outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_pulse   <= 1'b0;
      clk_pulse <= 1'b0;
      busy      <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      err_extra <= 1'b0;
    end else begin
      d_pulse   <= (state_nxt == S_DATA) && tx_shift_nxt[0];
      clk_pulse <= (state_nxt == S_CLOCK);
      busy      <= (state_nxt inside {S_DATA, S_SETUP, S_CLOCK, S_WAIT});
      rx_valid  <= (state_nxt == S_DONE);
      if (state_nxt == S_DONE) rx_data <= rx_shift_nxt;
      if (stray)       err_extra <= 1'b1;
      else if (accept) err_extra <= 1'b0;
    end
  end

`ifdef DRO_LOOPBACK_CHK_EN
  logic [WIDTH-1:0] tx_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_word  <= '0;
      mismatch <= 1'b0;
    end else if (accept) begin
      tx_word  <= tx_data;
      mismatch <= 1'b0;
    end else if (state_nxt == S_DONE) begin
      mismatch <= (rx_shift_nxt != tx_word);
    end
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_dro_pulse_driver.sv
// Self-checking bench for dro_pulse_driver: vector table, reset/back-to-back
// sequences, randomized words against a cycle-schedule model, and a second config.
module tb_dro_pulse_driver;

  localparam int WIDTH = 8;
  localparam int SETUP = 3;
  localparam int HOLD  = 2;
  localparam int WIN   = 4;
  localparam int WL    = (WIN > HOLD) ? WIN : HOLD;
  localparam int P     = 2 + SETUP + WL;
  localparam int N     = WIDTH * P;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [WIDTH-1:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic dro_out = 1'b0;
  logic tx_ready, d_pulse, clk_pulse, rx_valid, busy, err_extra, mismatch;
  logic [WIDTH-1:0] rx_data;

  logic [3:0] tx_data2 = '0;
  logic tx_valid2 = 1'b0;
  logic dro_out2 = 1'b0;
  logic tx_ready2, d_pulse2, clk_pulse2, rx_valid2, busy2, err_extra2, mismatch2;
  logic [3:0] rx_data2;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dro_pulse_driver #(.WIDTH(WIDTH), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .OUT_WIN(WIN)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .d_pulse(d_pulse), .clk_pulse(clk_pulse), .dro_out(dro_out), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .err_extra(err_extra), .mismatch(mismatch));

  dro_pulse_driver #(.WIDTH(4), .SETUP_CYC(1), .HOLD_CYC(6), .OUT_WIN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .d_pulse(d_pulse2), .clk_pulse(clk_pulse2), .dro_out(dro_out2), .rx_data(rx_data2),
    .rx_valid(rx_valid2), .busy(busy2), .err_extra(err_extra2), .mismatch(mismatch2));

  typedef struct {
    logic [WIDTH-1:0] word;
    int               dly;
    int               glitch;
    logic [WIDTH-1:0] exp_rx;
    bit               exp_err;
  } vec_t;

  vec_t tab[7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Runs one word starting at a negedge (time T); echo arrives dly cycles after each
  // clk_pulse of a 1 bit, plus an optional one-cycle glitch at relative cycle glitch.
  task automatic applyStimulus(input logic [WIDTH-1:0] word, input int dly, input int glitch,
                               input bit hold, input bit use_tab,
                               input logic [WIDTH-1:0] tab_rx, input bit tab_err);
    logic             sched [N+3];
    bit               err_at [N+3];
    logic [WIDTH-1:0] m_rx;
    logic             m_mm;
    bit               seen;
    int               k, o;
    for (int r = 0; r < N + 3; r++) sched[r] = 1'b0;
    for (int b = 0; b < WIDTH; b++)
      if (word[b] && dly > 0) sched[b*P + 2 + SETUP + dly] = 1'b1;
    if (glitch > 0) sched[glitch] = 1'b1;

    m_rx = '0;
    seen = 1'b0;
    for (int r = 1; r < N + 3; r++) begin
      bit win;
      err_at[r] = seen;
      win = 1'b0;
      if (r <= N) begin
        k = (r - 1) / P;
        o = (r - 1) % P;
        win = (o >= 2 + SETUP) && (o < 2 + SETUP + WIN);
        if (sched[r] && win) m_rx[k] = 1'b1;
      end
      if (sched[r] && !win) seen = 1'b1;
    end
`ifdef DRO_LOOPBACK_CHK_EN
    m_mm = (m_rx != word);
`else
    m_mm = 1'b0;
`endif

    tx_data  = word;
    tx_valid = 1'b1;
    dro_out  = 1'b0;
    checkOutput("tx_ready_at_accept", tx_ready, 1);
    for (int r = 1; r <= N + 2; r++) begin
      @(negedge clk);
      if (!hold) tx_valid = 1'b0;
      dro_out = (r <= N + 1) ? sched[r] : 1'b0;
      if (r <= N) begin
        k = (r - 1) / P;
        o = (r - 1) % P;
        checkOutput("d_pulse", d_pulse, (o == 0) && word[k]);
        checkOutput("clk_pulse", clk_pulse, o == 1 + SETUP);
      end else begin
        checkOutput("d_pulse_idle", d_pulse, 0);
        checkOutput("clk_pulse_idle", clk_pulse, 0);
      end
      checkOutput("busy", busy, r <= N);
      checkOutput("tx_ready", tx_ready, r == N + 2);
      checkOutput("rx_valid", rx_valid, r == N + 1);
      checkOutput("err_extra", err_extra, err_at[r]);
      checkOutput("mismatch", mismatch, (r > N) ? m_mm : 1'b0);
      if (r >= N + 1) begin
        checkOutput("rx_data_model", rx_data, m_rx);
        if (use_tab) checkOutput("rx_data_table", rx_data, tab_rx);
      end
      if (r == N + 2 && use_tab) checkOutput("err_extra_table", err_extra, tab_err);
    end
    dro_out = 1'b0;
  endtask

  initial begin
    tab[0] = '{8'hA5, 2, 0,  8'hA5, 1'b0};
    tab[1] = '{8'hFF, 0, 0,  8'h00, 1'b0};
    tab[2] = '{8'h5A, 2, 29, 8'h5A, 1'b1};
    tab[3] = '{8'h3C, 4, 0,  8'h3C, 1'b0};
    tab[4] = '{8'hC3, 1, 0,  8'hC3, 1'b0};
    tab[5] = '{8'h80, 5, 0,  8'h00, 1'b1};
    tab[6] = '{8'h01, 5, 0,  8'h00, 1'b1};

    #1;
    checkOutput("reset_tx_ready", tx_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_rx_data", rx_data, 0);
    checkOutput("reset_err_extra", err_extra, 0);
    checkOutput("reset_mismatch", mismatch, 0);
    checkOutput("reset_d_pulse", d_pulse, 0);
    checkOutput("reset_clk_pulse", clk_pulse, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++)
      applyStimulus(tab[i].word, tab[i].dly, tab[i].glitch, 1'b0, 1'b1, tab[i].exp_rx, tab[i].exp_err);

    // Back-to-back: tx_valid held, second word taken exactly two cycles after DONE.
    applyStimulus(8'h3C, 2, 0, 1'b1, 1'b1, 8'h3C, 1'b0);
    applyStimulus(8'hC3, 2, 0, 1'b0, 1'b1, 8'hC3, 1'b0);

    // Reset in the middle of bit 3 discards the word.
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    for (int r = 1; r <= 30; r++) begin
      @(negedge clk);
      tx_valid = 1'b0;
    end
    checkOutput("busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_d_pulse", d_pulse, 0);
    checkOutput("async_reset_clk_pulse", clk_pulse, 0);
    checkOutput("async_reset_busy", busy, 0);
    checkOutput("async_reset_tx_ready", tx_ready, 1);
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      checkOutput("no_rx_valid_in_reset", rx_valid, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("tx_ready_after_reset", tx_ready, 1);
    applyStimulus(8'h96, 2, 0, 1'b0, 1'b1, 8'h96, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] w;
      int d, g;
      w = WIDTH'($urandom);
      d = $urandom_range(0, WL + 1);
      g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N + 1) : 0;
      applyStimulus(w, d, g, 1'b0, 1'b0, '0, 1'b0);
    end

    // Second configuration: P=9, clk_pulse 2 after d, window 2 cycles, wait 6.
    tx_data2  = 4'b0011;
    tx_valid2 = 1'b1;
    checkOutput("cfg2_tx_ready", tx_ready2, 1);
    for (int r = 1; r <= 38; r++) begin
      int o2;
      @(negedge clk);
      tx_valid2 = 1'b0;
      dro_out2  = (r == 5) || (r == 16);
      o2 = (r - 1) % 9;
      checkOutput("cfg2_d_pulse", d_pulse2, (r <= 36) && (o2 == 0) && (r <= 18));
      checkOutput("cfg2_clk_pulse", clk_pulse2, (r <= 36) && (o2 == 2));
      checkOutput("cfg2_err_extra", err_extra2, r >= 17);
      checkOutput("cfg2_rx_valid", rx_valid2, r == 37);
      if (r >= 37) checkOutput("cfg2_rx_data", rx_data2, 4'b0001);
    end
    dro_out2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dro_pulse_driver.md
Name: dro_pulse_driver

Overview:
Clocked transmitter/initiator for a chain of destructive-readout (DRO) storage cells. It serialises a parallel word into DRO data pulses (d_pulse), each followed by a readout clock pulse (clk_pulse) that honours a programmable setup gap. It samples the DRO output pulse in a window after each readout and reassembles the received word. It sits between the digital test/control logic and the RSFQ DRO functional models, driving their d and clk inputs and monitoring their out.

Parameters:
WIDTH, 8, word width in bits; bits sent LSB first.
SETUP_CYC, 3, idle cycles between a d_pulse slot and its clk_pulse; legal range >=1.
HOLD_CYC, 2, minimum cycles after clk_pulse before the next d_pulse slot; legal range >=0.
OUT_WIN, 4, cycles after clk_pulse during which dro_out is sampled; legal range >=1.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
tx_data  input  WIDTH  word to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a word
d_pulse  output  1  registered data pulse to DRO d input
clk_pulse  output  1  registered readout pulse to DRO clk input
dro_out  input  1  DRO output pulse, synchronous to clk
rx_data  output  WIDTH  reassembled received word
rx_valid  output  1  one-cycle strobe, rx_data valid
busy  output  1  transfer in progress
err_extra  output  1  sticky: dro_out seen outside a sample window
mismatch  output  1  loopback compare result (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset (asynchronous, any time): state=IDLE, d_pulse=0, clk_pulse=0, rx_data=0, rx_valid=0, busy=0, err_extra=0, mismatch=0. An in-flight word is discarded with no rx_valid.
- tx_ready = (state==IDLE), decoded from state.
- Accept: tx_valid && tx_ready at edge T latches tx_data and clears err_extra and mismatch.
- FSM: IDLE -> DATA -> SETUP -> CLOCK -> WAIT -> (DATA for next bit | DONE) -> IDLE.
- Wait length W = max(OUT_WIN, HOLD_CYC).
- DATA, 1 cycle: d_pulse = current bit.
- SETUP, SETUP_CYC cycles: all pulses 0.
- CLOCK, 1 cycle: clk_pulse = 1, always, even for bit=0.
- WAIT, W cycles: sample window is the first OUT_WIN of them.
- Per-bit period P = 2 + SETUP_CYC + W. Defaults: P = 9; a word takes WIDTH*P = 72 cycles.
- Bit k: DATA at T+1+k*P. The final WAIT ends at T+WIDTH*P.
- DONE, 1 cycle at T+WIDTH*P+1: rx_valid = 1; rx_data holds its final value; busy = 0; tx_ready = 0. The next accept is possible at T+WIDTH*P+2.
- Bit capture: rx bit k = 1 iff dro_out = 1 on at least one cycle of bit k's sample window. Multi-cycle highs count once. A high on the last window cycle counts.
- err_extra is set when dro_out = 1 in any of:
  - IDLE, DATA, SETUP or CLOCK;
  - a WAIT cycle past OUT_WIN;
  - DONE.
  It holds until the next accept or reset.
- rx_data updates only at DONE; it holds otherwise.
- busy = 1 from DATA of bit 0 through the last WAIT.
- Counters are sized $clog2(max(SETUP_CYC, W, WIDTH)+1). They wrap only via reload; there is no free-running overflow.

Optional Feature:
DRO_LOOPBACK_CHK_EN:
- Defined: at DONE, mismatch <= (rx_data_final != latched tx word). It holds until the next accept or reset.
- Undefined: mismatch is tied 0 and the compare logic is absent. The port list is unchanged.

Test Plan:
- Reset, send 8'hA5 at T; bench DRO model echoes each clk_pulse 2 cycles later only if the preceding d_pulse was 1 -> d_pulse high at T+1+9k for k=0,2,5,7. clk_pulse at T+5+9k for k=0..7. rx_valid at T+73 with rx_data=8'hA5, err_extra=0, mismatch=0.
- dro_out held 0, send 8'hFF -> rx_data=8'h00 at T+73. mismatch=1 with DRO_LOOPBACK_CHK_EN, 0 without.
- Inject a 1-cycle dro_out pulse in the SETUP phase of bit 3 (T+29) -> err_extra=1 from T+30 until the next accept. rx_data is unaffected.
- rst_n low at T+30 -> d_pulse, clk_pulse and busy go 0 immediately. No rx_valid. tx_ready=1 after release; the next word completes correctly.
- tx_valid held high with words 8'h3C, 8'hC3 -> first accepted at T. tx_ready=0 from T+1 to T+73. Second accepted at T+74. Both rx_valid strobes are correct.
- WIDTH=4, SETUP_CYC=1, HOLD_CYC=6, OUT_WIN=2 -> P=9; clk_pulse 2 cycles after each d slot. An echo arriving 4 cycles after clk_pulse sets err_extra and yields rx bit 0.
